chan_sel_pipe: RTL and testbench
================================

CHAN_SEL_PIPE -- requirements
Module: chan_sel_pipe

Interface
REQ-001: Parameter W, default 8, data width per channel in bits (W >= 1).
REQ-002: Parameter N, default 4, number of input channels (2..16, power of two not required).
REQ-003: Derived constant SW = max(1, clog2(N)), select and source-index width.
REQ-004: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005: rst_n_i  input  1  reset, synchronous, active-low.
REQ-006: data_i  input  N*W  channel data, channel c in bits [c*W+W-1 : c*W].
REQ-007: valid_i  input  N  per-channel valid.
REQ-008: ready_o  output  N  per-channel ready; combinational, at most one bit set.
REQ-009: sel_i  input  SW  channel select, used in FIXED mode only.
REQ-010: mode_i  input  1  0 = FIXED, 1 = ROUND_ROBIN.
REQ-011: data_o  output  W  registered selected data.
REQ-012: src_o  output  SW  registered index of the channel that supplied data_o.
REQ-013: valid_o  output  1  registered output valid.
REQ-014: ready_i  input  1  downstream ready.

Function
REQ-015: The output stage shall be a single register slot; load_en = !valid_o || ready_i.
REQ-016: A transfer on channel c shall occur when valid_i[c] && ready_o[c]; data and index reach data_o/src_o with valid_o high on the next cycle (latency 1).
REQ-017: FIXED mode: grant = sel_i; ready_o[sel_i] = load_en, all other ready_o bits 0.
REQ-018: FIXED mode with sel_i >= N shall grant nothing: ready_o all 0, no load.
REQ-019: ROUND_ROBIN mode: grant the first channel with valid_i set, searching from rr_ptr upward and wrapping from N-1 to 0; ready_o[grant] = load_en.
REQ-020: On every ROUND_ROBIN transfer, rr_ptr shall become grant+1, or 0 when grant = N-1; otherwise rr_ptr shall hold.
REQ-021: FIXED-mode transfers shall not modify rr_ptr.
REQ-022: With no valid channel granted and valid_o && ready_i, valid_o shall clear; data_o/src_o shall hold their last values.
REQ-023: With valid_o && !ready_i, data_o, src_o and valid_o shall hold and all ready_o bits shall be 0.
REQ-024: A simultaneous downstream accept and new grant shall pass one item per cycle with no bubble.
REQ-025: A mode_i change takes effect in the same cycle's grant; the item already held in the output register is unaffected.

Reset
REQ-026: With rst_n_i low at a clock edge: valid_o = 0, data_o = 0, src_o = 0, rr_ptr = 0; ready_o shall be all 0 while rst_n_i is low.
REQ-027: Reset asserted mid-transfer shall discard the held item; no partial state survives.

Configuration
REQ-028: Macro CHAN_SEL_PIPE_CNT_EN defined: add output xfer_cnt_o (16 bits), counting downstream handshakes (valid_o && ready_i), wrapping 0xFFFF -> 0, reset to 0.
REQ-029: Macro CHAN_SEL_PIPE_CNT_EN undefined: the xfer_cnt_o port and counter logic shall not exist; all other behaviour is identical.

Structure
REQ-030: Package chan_sel_pkg shall hold the mode encodings MODE_FIXED = 1'b0 and MODE_RR = 1'b1 and the counter width constant CNT_W = 16.
REQ-031: The round-robin search and pointer shall form sub-module rr_arbiter (parameter N; inputs req, advance; outputs grant, grant_vld).

Verification
REQ-032: W=8, N=4, FIXED, sel_i=2, valid_i=4'b0100, data ch2=0xA5, ready_i=1 -> next cycle data_o=0xA5, src_o=2, valid_o=1.
REQ-033: ROUND_ROBIN, valid_i=4'b1111 held, ready_i=1, channel c data = 0x10+c -> src_o sequence 0,1,2,3,0; data_o 0x10,0x11,0x12,0x13,0x10.
REQ-034: Output valid with ready_i=0 for 3 cycles -> data_o/src_o stable, ready_o=0 throughout; ready_i=1 -> next item loads in the same cycle.
REQ-035: N=3, ROUND_ROBIN, valid_i=3'b101 -> src_o alternates 0,2,0,2; pointer wraps 2 -> 0; FIXED sel_i=3 -> no ready_o asserted.
REQ-036: rst_n_i low for one cycle while valid_o=1 -> valid_o=0, src_o=0, data_o=0; the first ROUND_ROBIN grant after reset is channel 0.
REQ-037: CHAN_SEL_PIPE_CNT_EN defined, 5 downstream handshakes -> xfer_cnt_o=5; counter preloaded to 0xFFFF + 1 handshake -> xfer_cnt_o=0.

Source files
------------

// File: rtl/chan_sel_pkg.sv
// chan_sel_pkg
// Shared constants for the channel-select pipeline: the mode encodings,
// the handshake-counter width and a helper that derives the select width
// from the channel count.
// Optional feature macro used by the design: CHAN_SEL_PIPE_CNT_EN
package chan_sel_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int CNT_W = 16;

    // Select/index width: max(1, clog2(n)).
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chan_sel_pipe_rr_arbiter.sv
// rr_arbiter
// Round-robin request search with a rotating start pointer. The grant is
// the first requesting channel at or above the pointer, wrapping from
// N-1 to 0. On advance the pointer moves to the channel after the grant.
// Ports:
//   clk_i     : clock
//   rst_n_i   : synchronous active-low reset (pointer back to 0)
//   req       : per-channel request vector
//   advance   : a transfer on the current grant happened this cycle
//   grant     : granted channel index (valid when grant_vld)
//   grant_vld : at least one request is present
module rr_arbiter
    import chan_sel_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = sel_width(N)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [SW-1:0] grant,
    output logic          grant_vld
);

    logic [SW-1:0] ptr_q;
    logic [SW-1:0] ptr_d;

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant     = SW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            if (int'(grant) == N - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant + SW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/chan_sel_pipe.sv
// chan_sel_pipe
// N-to-1 channel selector with a single registered output slot. The
// source channel is either fixed by sel_i or picked round-robin among the
// valid channels. Selected data and its channel index are registered with
// latency 1 and a valid/ready handshake downstream.
// Ports:
//   clk_i      : clock, all state on rising edge
//   rst_n_i    : synchronous active-low reset
//   data_i     : N*W channel data, channel c at [c*W +: W]
//   valid_i    : per-channel valid
//   ready_o    : per-channel ready, combinational, one-hot or zero
//   sel_i      : fixed-mode channel select
//   mode_i     : MODE_FIXED / MODE_RR
//   data_o     : registered selected data
//   src_o      : registered source channel index
//   valid_o    : registered output valid
//   ready_i    : downstream ready
//   xfer_cnt_o : downstream handshake count (only with CHAN_SEL_PIPE_CNT_EN)
// Optional feature macro: CHAN_SEL_PIPE_CNT_EN
module chan_sel_pipe
    import chan_sel_pkg::*;
#(
    parameter  int W  = 8,
    parameter  int N  = 4,
    localparam int SW = sel_width(N)
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic [N*W-1:0] data_i,
    input  logic [N-1:0]   valid_i,
    output logic [N-1:0]   ready_o,
    input  logic [SW-1:0]  sel_i,
    input  logic           mode_i,
    output logic [W-1:0]   data_o,
    output logic [SW-1:0]  src_o,
    output logic           valid_o,
    input  logic           ready_i
`ifdef CHAN_SEL_PIPE_CNT_EN
    ,
    output logic [CNT_W-1:0] xfer_cnt_o
`endif
);

    localparam int NP = 1 << SW;

    logic [W-1:0]  data_q,  data_d;
    logic [SW-1:0] src_q,   src_d;
    logic          valid_q, valid_d;

    logic          load_en;
    logic          fixed_vld;
    logic [SW-1:0] rr_grant;
    logic          rr_grant_vld;
    logic [SW-1:0] grant;
    logic          grant_vld;
    logic          xfer;
    logic          rr_advance;

    // Padded to a power of two so any select value indexes a real entry;
    // entries at or above N read as zero and are never transferred.
    logic [W-1:0]  ch_data [NP];

    for (genvar c = 0; c < NP; c++) begin : g_ch
        if (c < N) begin : g_real
            assign ch_data[c] = data_i[c*W +: W];
        end else begin : g_pad
            assign ch_data[c] = '0;
        end
    end

    rr_arbiter #(
        .N (N)
    ) u_rr_arbiter (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .req       (valid_i),
        .advance   (rr_advance),
        .grant     (rr_grant),
        .grant_vld (rr_grant_vld)
    );

    assign load_en   = !valid_q || ready_i;
    assign fixed_vld = (int'(sel_i) < N);

    always_comb begin
        if (mode_i == MODE_RR) begin
            grant     = rr_grant;
            grant_vld = rr_grant_vld;
        end else begin
            grant     = sel_i;
            grant_vld = fixed_vld;
        end
    end

    // Reset is folded in so ready_o stays low for the whole reset window,
    // not just after the first sampling edge.
    always_comb begin
        ready_o = '0;
        for (int c = 0; c < N; c++) begin
            ready_o[c] = rst_n_i && load_en && grant_vld && (int'(grant) == c);
        end
    end

    assign xfer       = |(ready_o & valid_i);
    assign rr_advance = xfer && (mode_i == MODE_RR);

    always_comb begin
        data_d  = data_q;
        src_d   = src_q;
        valid_d = valid_q;
        if (xfer) begin
            data_d  = ch_data[grant];
            src_d   = grant;
            valid_d = 1'b1;
        end else if (ready_i) begin
            // Slot drained with nothing to refill it; data/src keep last value.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            data_q  <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            src_q   <= src_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign src_o   = src_q;
    assign valid_o = valid_q;

`ifdef CHAN_SEL_PIPE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (valid_q && ready_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt_o = cnt_q;
`else
    // Handshake counter not built.
`endif

endmodule

// File: tb/tb_chan_sel_pipe.sv
// tb_chan_sel_pipe
// Directed bench for chan_sel_pipe: a W=8/N=4 instance and a W=8/N=3
// instance sharing clock and reset.
module tb_chan_sel_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic [31:0] data4;
    logic [3:0]  valid4;
    logic [3:0]  ready_o4;
    logic [1:0]  sel4;
    logic        mode4;
    logic [7:0]  dout4;
    logic [1:0]  src4;
    logic        vout4;
    logic        rdy4;

    logic [23:0] data3;
    logic [2:0]  valid3;
    logic [2:0]  ready_o3;
    logic [1:0]  sel3;
    logic        mode3;
    logic [7:0]  dout3;
    logic [1:0]  src3;
    logic        vout3;
    logic        rdy3;

`ifdef CHAN_SEL_PIPE_CNT_EN
    logic [15:0] cnt4;
    logic [15:0] cnt3;
`endif

    int total = 0;
    int bad   = 0;

    chan_sel_pipe #(.W(8), .N(4)) u_dut4 (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .data_i     (data4),
        .valid_i    (valid4),
        .ready_o    (ready_o4),
        .sel_i      (sel4),
        .mode_i     (mode4),
        .data_o     (dout4),
        .src_o      (src4),
        .valid_o    (vout4),
        .ready_i    (rdy4)
`ifdef CHAN_SEL_PIPE_CNT_EN
        ,
        .xfer_cnt_o (cnt4)
`endif
    );

    chan_sel_pipe #(.W(8), .N(3)) u_dut3 (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .data_i     (data3),
        .valid_i    (valid3),
        .ready_o    (ready_o3),
        .sel_i      (sel3),
        .mode_i     (mode3),
        .data_o     (dout3),
        .src_o      (src3),
        .valid_o    (vout3),
        .ready_i    (rdy3)
`ifdef CHAN_SEL_PIPE_CNT_EN
        ,
        .xfer_cnt_o (cnt3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_src4 [5];
        logic [1:0] exp_src3 [4];
        exp_src4 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_src3 = '{2'd0, 2'd2, 2'd0, 2'd2};

        rst_n  = 1'b0;
        data4  = '0; valid4 = '0; sel4 = '0; mode4 = 1'b0; rdy4 = 1'b0;
        data3  = '0; valid3 = '0; sel3 = '0; mode3 = 1'b0; rdy3 = 1'b0;
        tick();
        tick();

        // Reset state (FIXED sel=0 would otherwise raise ready_o[0])
        check("rst_valid4", vout4, 0);
        check("rst_data4", dout4, 0);
        check("rst_src4", src4, 0);
        check("rst_ready4", ready_o4, 0);
        check("rst_valid3", vout3, 0);
        check("rst_ready3", ready_o3, 0);

        rst_n = 1'b1;

        // FIXED select of channel 2
        mode4 = 1'b0; sel4 = 2'd2; valid4 = 4'b0100;
        data4 = {8'h00, 8'hA5, 8'h00, 8'h00}; rdy4 = 1'b1;
        #1;
        check("fix_ready", ready_o4, 4'b0100);
        tick();
        check("fix_data", dout4, 8'hA5);
        check("fix_src", src4, 2);
        check("fix_valid", vout4, 1);
        valid4 = 4'b0000;
        tick();
        check("drain_valid", vout4, 0);
        check("drain_data_hold", dout4, 8'hA5);
        check("drain_src_hold", src4, 2);

        // Round robin, all channels valid; pointer still 0
        mode4 = 1'b1; valid4 = 4'b1111;
        data4 = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_src", src4, exp_src4[k]);
            check("rr_data", dout4, 8'h10 + exp_src4[k]);
            check("rr_valid", vout4, 1);
        end

        // Back-pressure for 3 cycles, pointer now 1
        rdy4 = 1'b0;
        #1;
        check("stall_ready0", ready_o4, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_data", dout4, 8'h10);
            check("stall_src", src4, 0);
            check("stall_valid", vout4, 1);
            check("stall_ready", ready_o4, 0);
        end
        rdy4 = 1'b1;
        #1;
        check("unstall_ready", ready_o4, 4'b0010);
        tick();
        check("unstall_src", src4, 1);
        check("unstall_data", dout4, 8'h11);
        check("unstall_valid", vout4, 1);
        valid4 = 4'b0000;
        tick();
        check("idle_valid", vout4, 0);
        check("idle_data_hold", dout4, 8'h11);

        // Reset while holding an item; pointer was 3 before reset
        valid4 = 4'b1111;
        tick();
        check("pre_rst_src", src4, 2);
        check("pre_rst_valid", vout4, 1);
        rst_n = 1'b0;
        #1;
        check("in_rst_ready", ready_o4, 0);
        tick();
        check("post_rst_valid", vout4, 0);
        check("post_rst_src", src4, 0);
        check("post_rst_data", dout4, 0);
        rst_n = 1'b1;
        tick();
        check("first_rr_src", src4, 0);
        check("first_rr_data", dout4, 8'h10);

        // Mode change takes effect on the same cycle's grant
        mode4 = 1'b0; sel4 = 2'd3;
        tick();
        check("modechg_src", src4, 3);
        check("modechg_data", dout4, 8'h13);

        // N=3 round robin with a gap, then out-of-range FIXED select
        mode3 = 1'b1; valid3 = 3'b101; rdy3 = 1'b1;
        data3 = {8'h22, 8'h21, 8'h20};
        for (int k = 0; k < 4; k++) begin
            tick();
            check("n3_src", src3, exp_src3[k]);
            check("n3_data", dout3, 8'h20 + exp_src3[k]);
        end
        mode3 = 1'b0; sel3 = 2'd3; valid3 = 3'b111;
        #1;
        check("n3_oor_ready", ready_o3, 0);
        tick();
        check("n3_oor_valid", vout3, 0);
        check("n3_oor_data_hold", dout3, 8'h22);
        check("n3_oor_ready2", ready_o3, 0);

`ifdef CHAN_SEL_PIPE_CNT_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("cnt_rst", cnt4, 0);
        mode4 = 1'b1; valid4 = 4'b1111; rdy4 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
        end
        check("cnt_five", cnt4, 5);
        for (int k = 0; k < 65530; k++) begin
            tick();
        end
        check("cnt_max", cnt4, 16'hFFFF);
        tick();
        check("cnt_wrap", cnt4, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
